// File: rtl/otter_harness_pkg.sv
// Shared types for the OTTER bring-up harness: log entry, harness FSM state and
// the channel address decode helper.
package otter_harness_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } log_entry_t;

  typedef enum logic {HOLD, RUN} harness_state_t;

  typedef struct packed {
    logic        hit;
    logic [31:0] idx;
  } ch_hit_t;

  // Word-aligned address inside [base, base + 4*n) selects channel (addr-base)>>2.
  function automatic ch_hit_t ch_hit(input logic [31:0] addr, input logic [31:0] base,
                                     input int unsigned n);
    ch_hit_t     r;
    logic [31:0] off;
    off   = addr - base;
    r.idx = {2'b00, off[31:2]};
    r.hit = (addr[1:0] == 2'b00) && (addr >= base) && (r.idx < n);
    return r;
  endfunction

endpackage

// File: rtl/harness_log_fifo.sv
// Show-ahead write-log FIFO. A push into a full FIFO is dropped and latches the
// sticky overflow flag unless a pop frees the slot in the same cycle.
module harness_log_fifo
  import otter_harness_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  log_entry_t                 din,
  input  logic                       pop,
  output log_entry_t                 dout,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       ovf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  log_entry_t    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          full, push_ok, pop_ok;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  always_comb begin
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    wr_ptr_d = wr_ptr_q + PW'(push_ok);
    rd_ptr_d = rd_ptr_q + PW'(pop_ok);
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    ovf_d    = ovf_q | (push && !push_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: entries are only visible once count covers them.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign ovf   = ovf_q;

endmodule

// File: rtl/otter_io_harness.sv
// Bring-up harness around OTTER_TOP: CPU reset sequencing, periodic INTR, input
// channel reads and IOBUS write logging. OTTER_HARNESS_LOOPBACK_EN lets CPU writes
// to a channel address overwrite and freeze that channel.
module otter_io_harness
  import otter_harness_pkg::*;
#(
  parameter int          NUM_CH      = 4,
  parameter logic [31:0] BASE_ADDR   = 32'h1100_0000,
  parameter int          DEPTH       = 16,
  parameter int          RST_CYCLES  = 4,
  parameter int          INTR_PERIOD = 0,
  parameter int          INTR_WIDTH  = 1
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic [NUM_CH*32-1:0]       CH_IN,
  input  logic [31:0]                IOBUS_ADDR,
  input  logic [31:0]                IOBUS_OUT,
  input  logic                       IOBUS_WR,
  output logic [31:0]                IOBUS_IN,
  output logic                       CPU_RST,
  output logic                       INTR,
  input  logic                       LOG_RD,
  output logic                       LOG_VALID,
  output logic [31:0]                LOG_ADDR,
  output logic [31:0]                LOG_DATA,
  output logic [$clog2(DEPTH+1)-1:0] LOG_COUNT,
  output logic                       LOG_OVF
);

  localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int CW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  harness_state_t           state_q, state_d;
  logic [RCW-1:0]           rst_cnt_q, rst_cnt_d;
  logic [NUM_CH-1:0][31:0]  snap_q, snap_d;
  ch_hit_t                  hit;
  logic                     log_empty;
  log_entry_t               log_in, log_head;

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    case (state_q)
      HOLD: begin
        if (rst_cnt_q == RCW'(RST_CYCLES-1)) state_d = RUN;
        else                                 rst_cnt_d = rst_cnt_q + 1'b1;
      end
      default: ;
    endcase
  end

  assign CPU_RST = (state_q == HOLD);
  assign hit     = ch_hit(IOBUS_ADDR, BASE_ADDR, NUM_CH);

`ifdef OTTER_HARNESS_LOOPBACK_EN
  logic [NUM_CH-1:0] frz_q, frz_d;

  always_comb begin
    snap_d = CH_IN;
    frz_d  = frz_q;
    for (int k = 0; k < NUM_CH; k++) begin
      if (frz_q[k]) snap_d[k] = snap_q[k];
      if (state_q == RUN && IOBUS_WR && hit.hit && hit.idx == 32'(k)) begin
        snap_d[k] = IOBUS_OUT;
        frz_d[k]  = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) frz_q <= '0;
    else        frz_q <= frz_d;
  end
`else
  always_comb snap_d = CH_IN;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= HOLD;
      rst_cnt_q <= '0;
      snap_q    <= '0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      snap_q    <= snap_d;
    end
  end

  assign IOBUS_IN = hit.hit ? snap_q[hit.idx[CW-1:0]] : 32'h0;

  // INTR counter only exists when interrupts are enabled.
  if (INTR_PERIOD > 0) begin : g_intr
    localparam int ICW = (INTR_PERIOD > 1) ? $clog2(INTR_PERIOD) : 1;
    logic [ICW-1:0] intr_cnt_q, intr_cnt_d;

    always_comb begin
      intr_cnt_d = '0;
      if (state_q == RUN && intr_cnt_q != ICW'(INTR_PERIOD-1)) intr_cnt_d = intr_cnt_q + 1'b1;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) intr_cnt_q <= '0;
      else        intr_cnt_q <= intr_cnt_d;
    end

    assign INTR = (state_q == RUN) && (intr_cnt_q < ICW'(INTR_WIDTH));
  end else begin : g_no_intr
    assign INTR = 1'b0;
  end

  assign log_in = '{addr: IOBUS_ADDR, data: IOBUS_OUT};

  harness_log_fifo #(.DEPTH(DEPTH)) u_log (
    .clk   (CLK),
    .rst_n (RST_N),
    .push  (IOBUS_WR && state_q == RUN),
    .din   (log_in),
    .pop   (LOG_RD),
    .dout  (log_head),
    .empty (log_empty),
    .count (LOG_COUNT),
    .ovf   (LOG_OVF)
  );

  assign LOG_VALID = !log_empty;
  assign LOG_ADDR  = log_head.addr;
  assign LOG_DATA  = log_head.data;

endmodule
